// File: rtl/vnc2_uart_tx.sv
// vnc2_uart_tx
//   Byte-oriented 8N1 serial transmitter (LSB first) toward the VNC2 USB host
//   controller. A small circular FIFO absorbs bursty writers. A four-state
//   serializer drains it one frame per 10*BAUD_DIV clocks, with no idle gap
//   between back-to-back frames.
// Ports
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-high; line forced high, FIFO flushed
//   data_i  : byte to transmit
//   wr_i    : single-cycle write strobe (ignored while full_o)
//   full_o  : FIFO holds 2**FIFO_AW bytes
//   empty_o : FIFO holds no bytes
//   busy_o  : serializer is not idle
//   tx_o    : registered serial line, idle high
module vnc2_uart_tx #(
  parameter int BAUD_DIV = 434,
  parameter int FIFO_AW  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_i,
  input  logic       wr_i,
  output logic       full_o,
  output logic       empty_o,
  output logic       busy_o,
  output logic       tx_o
);

  localparam int             DEPTH      = 1 << FIFO_AW;
  localparam logic [15:0]    BAUD_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [FIFO_AW:0] COUNT_FULL = DEPTH[FIFO_AW:0];

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [FIFO_AW:0]   r_count;

  // Serializer
  state_t      r_state, w_state_nxt;
  logic [15:0] r_baud,  w_baud_nxt;
  logic [2:0]  r_bit,   w_bit_nxt;
  logic [7:0]  r_sh,    w_sh_nxt;
  logic        r_tx,    w_tx_nxt;

  logic w_push, w_pop, w_have, w_bit_end;

  assign full_o    = (r_count == COUNT_FULL);
  assign empty_o   = (r_count == '0);
  assign w_have    = !empty_o;
  // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign w_push    = wr_i && !full_o;
  assign w_bit_end = (r_baud == BAUD_LAST);
  assign busy_o    = (r_state != S_IDLE);
  assign tx_o      = r_tx;

  // FIFO data array (no reset needed: contents are only read when count != 0)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_sh    <= w_sh_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_sh_nxt    = r_sh;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_have) begin
          w_pop       = 1'b1;
          w_sh_nxt    = r_mem[r_rd_ptr];
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt  = r_baud + 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          w_sh_nxt   = {1'b0, r_sh[7:1]};
          w_bit_nxt  = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          // Chain straight into the next start bit when more data is queued.
          if (w_have) begin
            w_pop       = 1'b1;
            w_sh_nxt    = r_mem[r_rd_ptr];
            w_bit_nxt   = '0;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line level is derived from the upcoming state so tx_o is a clean flop output.
  always_comb begin
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_sh_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_vnc2_uart_tx.sv
module tb_vnc2_uart_tx;
  localparam int D     = 4;
  localparam int FRAME = 10 * D;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       full_o, empty_o, busy_o, tx_o;

  int tests = 0;
  int fails = 0;

  // Reference model: a byte queue plus position inside the current frame.
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  int         m_pos = -1;
  logic [7:0] m_cur = 8'h00;

  // Line decoder state
  logic [7:0] rx_q[$];
  int         rx_cnt = -1;
  logic [7:0] rx_sh = 8'h00;
  int         busy_cycles = 0;

  vnc2_uart_tx #(.BAUD_DIV(D), .FIFO_AW(3)) dut (
    .clk(clk), .reset(reset), .data_i(data_i), .wr_i(wr_i),
    .full_o(full_o), .empty_o(empty_o), .busy_o(busy_o), .tx_o(tx_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_tx();
    int b;
    if (m_pos < 0) return 1'b1;
    b = m_pos / D;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  task automatic model_edge(input logic w, input logic [7:0] d);
    int n;
    bit pop;
    n   = m_q.size();
    pop = (n > 0) && (m_pos < 0 || m_pos == FRAME - 1);
    if (m_pos == FRAME - 1) m_sent.push_back(m_cur);
    if (pop) begin
      m_cur = m_q.pop_front();
      m_pos = 0;
    end else if (m_pos == FRAME - 1) m_pos = -1;
    else if (m_pos >= 0) m_pos++;
    if (w && n < 8) m_q.push_back(d);
  endtask

  task automatic tick(input logic w, input logic [7:0] d);
    wr_i   = w;
    data_i = d;
    @(posedge clk);
    model_edge(w, d);
    #1;
    chk("tx",    {31'd0, tx_o},    {31'd0, exp_tx()});
    chk("busy",  {31'd0, busy_o},  {31'd0, m_pos >= 0});
    chk("full",  {31'd0, full_o},  {31'd0, m_q.size() == 8});
    chk("empty", {31'd0, empty_o}, {31'd0, m_q.size() == 0});
    if (busy_o) busy_cycles++;
    // Decode the line independently: find start, sample mid-bit.
    if (rx_cnt < 0) begin
      if (tx_o == 1'b0) rx_cnt = 0;
    end else begin
      rx_cnt++;
      if (rx_cnt >= D + D/2 && rx_cnt < 9*D && (rx_cnt - D/2) % D == 0)
        rx_sh[(rx_cnt - D/2) / D - 1] = tx_o;
      if (rx_cnt == 9*D + D/2) begin
        chk("stop_bit", {31'd0, tx_o}, 32'd1);
        rx_q.push_back(rx_sh);
        rx_cnt = -1;
      end
    end
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while ((m_pos >= 0 || m_q.size() > 0) && k < limit) begin
      tick(1'b0, 8'h00);
      k++;
    end
    chk("idle_bound", {31'd0, k < limit}, 32'd1);
    repeat (D) tick(1'b0, 8'h00);
  endtask

  task automatic check_bytes(input string tag);
    chk({tag, "_nbytes"}, rx_q.size(), m_sent.size());
    for (int i = 0; i < rx_q.size() && i < m_sent.size(); i++)
      chk({tag, "_byte"}, {24'd0, rx_q[i]}, {24'd0, m_sent[i]});
    rx_q.delete();
    m_sent.delete();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_tx",    {31'd0, tx_o},    32'd1);
    chk("rst_busy",  {31'd0, busy_o},  32'd0);
    chk("rst_empty", {31'd0, empty_o}, 32'd1);
    chk("rst_full",  {31'd0, full_o},  32'd0);
    m_q.delete();
    m_pos  = -1;
    rx_cnt = -1;
    #2 reset = 1'b0;
  endtask

  initial begin
    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk("por_tx",    {31'd0, tx_o},    32'd1);
    chk("por_busy",  {31'd0, busy_o},  32'd0);
    chk("por_empty", {31'd0, empty_o}, 32'd1);
    chk("por_full",  {31'd0, full_o},  32'd0);
    reset = 1'b0;

    // Idle line stays high
    repeat (1000) tick(1'b0, 8'h00);

    // Single byte
    busy_cycles = 0;
    tick(1'b1, 8'hA5);
    wait_idle(200);
    chk("a5_busy_cycles", busy_cycles, FRAME);
    chk("a5_rx_n", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("a5_rx", {24'd0, rx_q[0]}, 32'hA5);
    check_bytes("single");

    // Back-to-back
    tick(1'b1, 8'h55);
    tick(1'b1, 8'h0F);
    tick(1'b1, 8'hFF);
    wait_idle(400);
    check_bytes("b2b");

    // Overflow: ten writes, the last one is refused
    for (int i = 0; i < 10; i++) tick(1'b1, 8'(i));
    wait_idle(1000);
    chk("ovf_n", rx_q.size(), 9);
    for (int i = 0; i < rx_q.size() && i < 9; i++)
      chk("ovf_byte", {24'd0, rx_q[i]}, i);
    check_bytes("ovf");

    // Reset in the middle of DATA bit 3 of a queued burst
    for (int i = 0; i < 4; i++) tick(1'b1, 8'($urandom));
    for (int k = 0; k < 200 && m_pos != 4*D + 1; k++) tick(1'b0, 8'h00);
    chk("midrst_reach", m_pos, 4*D + 1);
    do_reset();
    repeat (200) tick(1'b0, 8'h00);
    chk("midrst_empty", {31'd0, empty_o}, 32'd1);
    chk("midrst_rx_n", rx_q.size(), 0);
    check_bytes("midrst");

    // Wrap-around with random bursts and gaps
    for (int r = 0; r < 20; r++) begin
      int n;
      n = $urandom_range(1, 9);
      for (int j = 0; j < n; j++) begin
        tick(1'b1, 8'($urandom));
        if ($urandom_range(0, 3) == 0) tick(1'b0, 8'h00);
      end
      if ($urandom_range(0, 1) == 0) wait_idle(FRAME * 12);
    end
    wait_idle(FRAME * 12);
    check_bytes("wrap");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
